demux_router: RTL and testbench
===============================

// Module: demux_router
// PURPOSE
//   Registered 1-to-NOUT stream demultiplexer, the distribution side of the 4:1 selector.
//   Accepts one beat (data + destination select) over a valid/ready handshake.
//   Holds the beat in a single-entry buffer and presents it to exactly one output port
//   until that port accepts it. Sits between a shared producer and NOUT consumer lanes.
// PARAMETERS
//   DW    8   data width in bits
//   NOUT  4   number of output lanes, 2..16
//   SELW  $clog2(NOUT)  select width (derived; do not override)
//   CNTW  8   width of each per-lane delivered-beat counter (ROUTE_STATS_EN only)
// PORTS
//   clk        in   1          clock, all logic on rising edge
//   rst        in   1          synchronous reset, active-high
//   in_valid   in   1          producer beat valid
//   in_ready   out  1          block can take a beat this cycle
//   in_data    in   DW         beat payload
//   in_sel     in   SELW       destination lane index
//   out_valid  out  NOUT       one-hot (or zero) lane valid
//   out_ready  in   NOUT       per-lane consumer ready
//   out_data   out  DW         payload, broadcast to all lanes, qualified by out_valid
//   err_sel    out  1          1-cycle pulse: accepted beat had in_sel >= NOUT
//   lane_cnt   out  NOUT*CNTW  per-lane delivered counts, lane i at [i*CNTW +: CNTW]
// BEHAVIOUR
//   - Reset (sync, rst=1 at clk edge): state=EMPTY, out_valid=0, out_data=0, sel_q=0,
//     err_sel=0, lane_cnt=0. Any held beat is discarded, including one mid-handshake.
//   - FSM with two states:
//     EMPTY: go to FULL on in_valid & in_ready with a legal select.
//     FULL:  go to EMPTY on delivery (out_ready[sel_q]) with no new accept.
//            Stay FULL on delivery plus a new accept (back-to-back).
//   - in_ready = (state==EMPTY) | (state==FULL & out_ready[sel_q]). Combinational from out_ready.
//   - Accept: data_q<=in_data and sel_q<=in_sel. Latency is 1 cycle: out_valid rises the cycle after the accept.
//   - out_valid[i] = (state==FULL) & (sel_q==i). Driven from one always_comb only; never more than one bit set.
//   - Delivery = out_valid[sel_q] & out_ready[sel_q]. Other lanes' out_ready are ignored.
//   - Backpressure: while out_valid[i] & ~out_ready[i], out_data and sel_q stay stable
//     and in_ready=0.
//   - Full throughput: one beat per cycle when the target lane keeps out_ready=1.
//   - Illegal select (in_sel>=NOUT, only possible when NOUT is not a power of 2):
//     the beat is accepted and dropped, and err_sel=1 in the next cycle.
//     FSM moves to EMPTY when the accept coincides with a delivery, else it stays in EMPTY.
//   - in_valid is not sticky. Whatever the producer holds while in_ready=0 is not captured.
//   - out_data is 0 only after reset. Afterwards it keeps the last beat while EMPTY.
// CONFIGURATION
//   ROUTE_STATS_EN defined:
//     - lane_cnt[i] increments on each delivery to lane i.
//     - It saturates at 2**CNTW-1 and no wrap is allowed.
//     - Cleared by rst only.
//   ROUTE_STATS_EN undefined:
//     - lane_cnt tied to 0.
//     - No counter flops are synthesised.
//     - Port list unchanged.
// STRUCTURE
//   - demux_router_pkg:
//     - typedef enum logic {EMPTY, FULL} rt_state_e;
//     - localparam for max NOUT (16).
//   - Sub-module sat_counter #(CNTW): clk, rst, inc, count.
//     Instanced NOUT times via generate under ROUTE_STATS_EN.
//   - Each signal has exactly one driving procedure:
//     - always_ff for state/data_q/sel_q/err_sel;
//     - always_comb for in_ready/out_valid.
// TESTING
//   1. Reset: rst=1 for 2 cycles while in_valid=1 -> out_valid=0, in_ready=1 after release, lane_cnt=0.
//   2. Single route: in_data=8'hA5, in_sel=2, out_ready=4'b0100
//      -> next cycle out_valid=4'b0100, out_data=A5.
//      Delivered; with ROUTE_STATS_EN lane_cnt[2]=1.
//   3. Backpressure: beat to lane 1, out_ready[1]=0 for 5 cycles
//      -> out_valid=4'b0010 and out_data held, in_ready=0 throughout.
//      out_ready[3]=1 has no effect.
//   4. Streaming: 8 beats sel=0..3 repeating, all out_ready=1
//      -> one delivery per cycle, in order, in_ready stays 1.
//      lane_cnt each =2.
//   5. Illegal select (NOUT=3): in_sel=3 -> err_sel pulses once, no out_valid, lane_cnt unchanged.
//   6. Saturation (CNTW=2): 5 deliveries to lane 0 -> lane_cnt[0]=3.
//      Reset asserted while FULL -> out_valid=0 next cycle, beat lost.

Source files
------------

// File: rtl/demux_router_pkg.sv
// Shared types for the demux_router slice: FSM state encoding and lane-count limit.
// Purely declarative; no latency or backpressure of its own.
package demux_router_pkg;

    typedef enum logic {EMPTY, FULL} rt_state_e;

    localparam int MAX_NOUT = 16;

endpackage

// File: rtl/demux_router_sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones, 1-cycle update.
// No backpressure; cleared only by rst.
module sat_counter #(
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [CNTW-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNTW{1'b1}})) begin
            count <= count + CNTW'(1);
        end
    end

endmodule

// File: rtl/demux_router.sv
// Single-entry 1-to-NOUT demux: beat appears on its lane 1 cycle after accept; in_ready drops while the target lane stalls.
// Define ROUTE_STATS_EN to build the per-lane saturating delivery counters on lane_cnt.
module demux_router
    import demux_router_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NOUT = 4,
    parameter int SELW = $clog2(NOUT),
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic [SELW-1:0]      in_sel,
    output logic [NOUT-1:0]      out_valid,
    input  logic [NOUT-1:0]      out_ready,
    output logic [DW-1:0]        out_data,
    output logic                 err_sel,
    output logic [NOUT*CNTW-1:0] lane_cnt
);

    rt_state_e       state_q;
    rt_state_e       state_d;
    logic [DW-1:0]   data_q;
    logic [SELW-1:0] sel_q;
    logic            deliver;
    logic            accept;
    logic            sel_legal;

    // Only reachable for non-power-of-two NOUT; such beats are consumed and dropped.
    assign sel_legal = (int'(in_sel) < NOUT);
    assign accept    = in_valid & in_ready;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept && sel_legal) begin
            state_d = FULL;
        end else if (deliver) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        out_valid = '0;
        deliver   = 1'b0;
        for (int i = 0; i < NOUT; i++) begin
            if ((state_q == FULL) && (sel_q == SELW'(i))) begin
                out_valid[i] = 1'b1;
                deliver      = out_ready[i];
            end
        end
        in_ready = (state_q == EMPTY) | deliver;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            err_sel <= 1'b0;
        end else begin
            err_sel <= accept & ~sel_legal;
            if (accept && sel_legal) begin
                data_q <= in_data;
                sel_q  <= in_sel;
            end
        end
    end

`ifdef ROUTE_STATS_EN
    for (genvar i = 0; i < NOUT; i++) begin : g_lane_cnt
        sat_counter #(
            .CNTW (CNTW)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (out_valid[i] & out_ready[i]),
            .count (lane_cnt[i*CNTW +: CNTW])
        );
    end
`else
    assign lane_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_router.sv
// Directed bench: 4-lane instance for routing/backpressure/streaming, 3-lane CNTW=2 instance for illegal select and saturation.
module tb_demux_router;

`ifdef ROUTE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, err_sel;
    logic [7:0]  in_data, out_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid, out_ready;
    logic [31:0] lane_cnt;

    logic        in_valid3, in_ready3, err_sel3;
    logic [7:0]  in_data3, out_data3;
    logic [1:0]  in_sel3;
    logic [2:0]  out_valid3, out_ready3;
    logic [5:0]  lane_cnt3;

    int n_cmp = 0;
    int n_bad = 0;

    demux_router #(.DW(8), .NOUT(4), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .err_sel(err_sel),
        .lane_cnt(lane_cnt)
    );

    demux_router #(.DW(8), .NOUT(3), .CNTW(2)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .in_sel(in_sel3), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_data(out_data3), .err_sel(err_sel3),
        .lane_cnt(lane_cnt3)
    );

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_valid3 = 1'b0;
        out_ready = '0;  out_ready3 = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;  in_data = 8'hFF;  in_sel = 2'd1;  out_ready = 4'b0000;
        in_valid3 = 1'b1; in_data3 = 8'hEE; in_sel3 = 2'd1; out_ready3 = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL rst_out_valid got %b want 0000", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data got %h want 00", out_data); end
        n_cmp++; if (err_sel !== 1'b0) begin n_bad++; $display("FAIL rst_err_sel got %b want 0", err_sel); end
        n_cmp++; if (lane_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_lane_cnt got %h want 0", lane_cnt); end
        n_cmp++; if (out_valid3 !== 3'b000) begin n_bad++; $display("FAIL rst_out_valid3 got %b want 000", out_valid3); end
        n_cmp++; if (lane_cnt3 !== 6'h0) begin n_bad++; $display("FAIL rst_lane_cnt3 got %h want 0", lane_cnt3); end
    endtask

    task automatic test_single_route();
        in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2; out_ready = 4'b0100;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'b0100) begin n_bad++; $display("FAIL single_out_valid got %b want 0100", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL single_out_data got %h want a5", out_data); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL single_drained got %b want 0000", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL single_data_kept got %h want a5", out_data); end
        n_cmp++; if (lane_cnt[16 +: 8] !== (STATS ? 8'd1 : 8'd0)) begin n_bad++; $display("FAIL single_lane_cnt2 got %0d want %0d", lane_cnt[16 +: 8], STATS ? 1 : 0); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_data = 8'h3C; in_sel = 2'd1; out_ready = 4'b1000;
        @(negedge clk);
        // Producer keeps offering a different beat while stalled; it must never be taken.
        in_data = 8'h77; in_sel = 2'd0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (out_valid !== 4'b0010) begin n_bad++; $display("FAIL bp_out_valid[%0d] got %b want 0010", c, out_valid); end
            n_cmp++; if (out_data !== 8'h3C) begin n_bad++; $display("FAIL bp_out_data[%0d] got %h want 3c", c, out_data); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 4'b0010;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL bp_drained got %b want 0000", out_valid); end
        n_cmp++; if (out_data !== 8'h3C) begin n_bad++; $display("FAIL bp_not_sticky got %h want 3c", out_data); end
        n_cmp++; if (lane_cnt !== (STATS ? 32'h0001_0100 : 32'h0)) begin n_bad++; $display("FAIL bp_lane_cnt got %h want %h", lane_cnt, STATS ? 32'h0001_0100 : 32'h0); end
        out_ready = 4'b0000;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 4'b1111;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; in_data = 8'(8'h10 + i); in_sel = 2'(i % 4);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
            if (i > 0) begin
                n_cmp++; if (out_valid !== (4'b0001 << ((i - 1) % 4))) begin n_bad++; $display("FAIL stream_out_valid[%0d] got %b want %b", i, out_valid, 4'b0001 << ((i - 1) % 4)); end
                n_cmp++; if (out_data !== 8'(8'h10 + i - 1)) begin n_bad++; $display("FAIL stream_out_data[%0d] got %h want %h", i, out_data, 8'(8'h10 + i - 1)); end
            end
            @(negedge clk);
        end
        n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL stream_drained got %b want 0000", out_valid); end
        n_cmp++; if (lane_cnt !== (STATS ? 32'h0202_0202 : 32'h0)) begin n_bad++; $display("FAIL stream_lane_cnt got %h want %h", lane_cnt, STATS ? 32'h0202_0202 : 32'h0); end
        out_ready = 4'b0000;
    endtask

    task automatic test_illegal_sel();
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'h55; out_ready3 = 3'b111;
        #1;
        n_cmp++; if (in_ready3 !== 1'b1) begin n_bad++; $display("FAIL ill_in_ready got %b want 1", in_ready3); end
        @(negedge clk);
        in_valid3 = 1'b0;
        n_cmp++; if (err_sel3 !== 1'b1) begin n_bad++; $display("FAIL ill_err_pulse got %b want 1", err_sel3); end
        n_cmp++; if (out_valid3 !== 3'b000) begin n_bad++; $display("FAIL ill_out_valid got %b want 000", out_valid3); end
        n_cmp++; if (out_data3 !== 8'h00) begin n_bad++; $display("FAIL ill_out_data got %h want 00", out_data3); end
        @(negedge clk);
        n_cmp++; if (err_sel3 !== 1'b0) begin n_bad++; $display("FAIL ill_err_once got %b want 0", err_sel3); end
        n_cmp++; if (lane_cnt3 !== 6'h0) begin n_bad++; $display("FAIL ill_lane_cnt got %h want 0", lane_cnt3); end
        // Illegal accept coinciding with a delivery must leave the buffer empty.
        in_valid3 = 1'b1; in_sel3 = 2'd2; in_data3 = 8'h11; out_ready3 = 3'b000;
        @(negedge clk);
        n_cmp++; if (out_valid3 !== 3'b100) begin n_bad++; $display("FAIL ill_hold_valid got %b want 100", out_valid3); end
        in_sel3 = 2'd3; in_data3 = 8'h66; out_ready3 = 3'b100;
        #1;
        n_cmp++; if (in_ready3 !== 1'b1) begin n_bad++; $display("FAIL ill_dlv_in_ready got %b want 1", in_ready3); end
        @(negedge clk);
        in_valid3 = 1'b0;
        n_cmp++; if (err_sel3 !== 1'b1) begin n_bad++; $display("FAIL ill_dlv_err got %b want 1", err_sel3); end
        n_cmp++; if (out_valid3 !== 3'b000) begin n_bad++; $display("FAIL ill_dlv_empty got %b want 000", out_valid3); end
        n_cmp++; if (out_data3 !== 8'h11) begin n_bad++; $display("FAIL ill_dlv_data got %h want 11", out_data3); end
        @(negedge clk);
        n_cmp++; if (err_sel3 !== 1'b0) begin n_bad++; $display("FAIL ill_dlv_err_once got %b want 0", err_sel3); end
    endtask

    task automatic test_saturation();
        out_ready3 = 3'b111;
        for (int i = 0; i < 5; i++) begin
            in_valid3 = 1'b1; in_sel3 = 2'd0; in_data3 = 8'(i);
            @(negedge clk);
        end
        in_valid3 = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid3 !== 3'b000) begin n_bad++; $display("FAIL sat_drained got %b want 000", out_valid3); end
        n_cmp++; if (lane_cnt3 !== (STATS ? 6'b01_00_11 : 6'h0)) begin n_bad++; $display("FAIL sat_lane_cnt got %b want %b", lane_cnt3, STATS ? 6'b01_00_11 : 6'h0); end
        in_valid3 = 1'b1; in_sel3 = 2'd1; in_data3 = 8'h9A; out_ready3 = 3'b000;
        @(negedge clk);
        in_valid3 = 1'b0;
        n_cmp++; if (out_valid3 !== 3'b010) begin n_bad++; $display("FAIL rstfull_pre got %b want 010", out_valid3); end
        n_cmp++; if (out_data3 !== 8'h9A) begin n_bad++; $display("FAIL rstfull_pre_data got %h want 9a", out_data3); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (out_valid3 !== 3'b000) begin n_bad++; $display("FAIL rstfull_valid got %b want 000", out_valid3); end
        n_cmp++; if (out_data3 !== 8'h00) begin n_bad++; $display("FAIL rstfull_data got %h want 00", out_data3); end
        n_cmp++; if (lane_cnt3 !== 6'h0) begin n_bad++; $display("FAIL rstfull_lane_cnt got %h want 0", lane_cnt3); end
        out_ready3 = 3'b111;
        @(negedge clk);
        n_cmp++; if (out_valid3 !== 3'b000) begin n_bad++; $display("FAIL rstfull_lost got %b want 000", out_valid3); end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;  in_data = '0;  in_sel = '0;  out_ready = '0;
        in_valid3 = 1'b0; in_data3 = '0; in_sel3 = '0; out_ready3 = '0;
        @(negedge clk);
        test_reset();
        test_single_route();
        test_backpressure();
        test_back_to_back();
        test_illegal_sel();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
